oam_dma_controller: RTL

OAM DMA controller for the GBoilerC system bus. A CPU write to register FF46 latches a source page and starts a copy of `LENGTH` bytes from `{page,8'h00}` to OAM at `FE00`, one byte per M-cycle. While the copy runs, the block owns the memory bus and tells the bus glue which CPU accesses to block. It sits beside the CPU control unit, shares its clock enable, and arbitrates the single memory port between the CPU and DMA.

---
 rtl/oam_dma_controller_if.sv | 27 ++
 rtl/oam_dma_controller.sv | 135 +++++++++++++
 2 files changed

// File: rtl/oam_dma_controller_if.sv
// Memory-port bundle between the OAM DMA engine (master) and the bus glue/memory (slave).
interface oam_dma_controller_if;
    logic [15:0] o_Src_Address;
    logic [15:0] o_Dst_Address;
    logic        o_Mem_Read;
    logic        o_Mem_Write;
    logic [7:0]  o_Mem_Data;
    logic [7:0]  i_Mem_Data;

    modport master (
        output o_Src_Address,
        output o_Dst_Address,
        output o_Mem_Read,
        output o_Mem_Write,
        output o_Mem_Data,
        input  i_Mem_Data
    );

    modport slave (
        input  o_Src_Address,
        input  o_Dst_Address,
        input  o_Mem_Read,
        input  o_Mem_Write,
        input  o_Mem_Data,
        output i_Mem_Data
    );
endinterface

// File: rtl/oam_dma_controller.sv
// OAM DMA: a write to FF46 copies LENGTH bytes from {page,00} to FE00, one byte per M-cycle,
// while blocking non-HRAM CPU accesses.
module oam_dma_controller #(
    parameter int unsigned LENGTH  = 160,
    parameter int unsigned T_PER_M = 4
) (
    input  logic        i_Clk,
    input  logic        i_nRst,
    input  logic        i_Enable,
    input  logic        i_Reg_Write,
    input  logic [7:0]  i_Data,
    output logic [7:0]  o_Data,
    input  logic [15:0] i_Cpu_Address,
    output logic        o_Cpu_Block,
    output logic        o_Busy,
    output logic        o_Active,
    oam_dma_controller_if.master io_Mem
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        XFER
    } state_t;

    localparam logic [1:0] T_LAST = 2'(T_PER_M - 1);
    localparam logic [7:0] N_LAST = 8'(LENGTH - 1);

    state_t      r_State, w_State_Next;
    logic [1:0]  r_T, w_T_Next;
    logic [7:0]  r_N, w_N_Next;
    logic [7:0]  r_Page, w_Page_Next;
    logic [7:0]  r_Byte, w_Byte_Next;
    logic [15:0] r_Src_Hold, w_Src_Hold_Next;
    logic [15:0] r_Dst_Hold, w_Dst_Hold_Next;

    logic [7:0]  w_Mapped_Page;
    logic [15:0] w_Src_Live;
    logic [15:0] w_Dst_Live;
    logic        w_Addr_Live;
    logic        w_Hram;

    always_ff @(posedge i_Clk or negedge i_nRst) begin
        if (!i_nRst) begin
            r_State    <= IDLE;
            r_T        <= '0;
            r_N        <= '0;
            r_Page     <= 8'hFF;
            r_Byte     <= '0;
            r_Src_Hold <= 16'hFF00;
            r_Dst_Hold <= 16'hFE00;
        end else begin
            r_State    <= w_State_Next;
            r_T        <= w_T_Next;
            r_N        <= w_N_Next;
            r_Page     <= w_Page_Next;
            r_Byte     <= w_Byte_Next;
            r_Src_Hold <= w_Src_Hold_Next;
            r_Dst_Hold <= w_Dst_Hold_Next;
        end
    end

    // Echo RAM pages E0..FF alias work RAM at C0..DF.
    always_comb begin
        w_Mapped_Page = (r_Page >= 8'hE0) ? (r_Page - 8'h20) : r_Page;
        w_Src_Live    = {w_Mapped_Page, r_N};
        w_Dst_Live    = 16'hFE00 + {8'h00, r_N};
        w_Addr_Live   = (r_State == XFER) && (r_T != T_LAST);
    end

    always_comb begin
        w_State_Next    = r_State;
        w_T_Next        = r_T;
        w_N_Next        = r_N;
        w_Page_Next     = r_Page;
        w_Byte_Next     = r_Byte;
        w_Src_Hold_Next = r_Src_Hold;
        w_Dst_Hold_Next = r_Dst_Hold;

        if (i_Enable) begin
            case (r_State)
                START: begin
                    w_T_Next = r_T + 2'd1;
                    if (r_T == T_LAST) begin
                        w_State_Next = XFER;
                    end
                end
                XFER: begin
                    w_T_Next = r_T + 2'd1;
                    if (r_T == 2'd1) begin
                        w_Byte_Next = io_Mem.i_Mem_Data;
                    end
                    if (w_Addr_Live) begin
                        w_Src_Hold_Next = w_Src_Live;
                        w_Dst_Hold_Next = w_Dst_Live;
                    end
                    if (r_T == T_LAST) begin
                        if (r_N == N_LAST) begin
                            w_State_Next = IDLE;
                            w_N_Next     = '0;
                        end else begin
                            w_N_Next = r_N + 8'd1;
                        end
                    end
                end
                default: begin
                end
            endcase

            // A register write overrides everything, including the final step of a transfer.
            if (i_Reg_Write) begin
                w_Page_Next  = i_Data;
                w_T_Next     = '0;
                w_N_Next     = '0;
                w_State_Next = START;
            end
        end
    end

    always_comb begin
        w_Hram = (i_Cpu_Address >= 16'hFF80) && (i_Cpu_Address <= 16'hFFFE);

        o_Data      = r_Page;
        o_Busy      = (r_State != IDLE);
        o_Active    = (r_State == XFER);
        o_Cpu_Block = o_Active & ~w_Hram;

        io_Mem.o_Mem_Read    = (r_State == XFER) && (r_T <= 2'd1);
        io_Mem.o_Mem_Write   = (r_State == XFER) && (r_T == 2'd2);
        io_Mem.o_Mem_Data    = r_Byte;
        io_Mem.o_Src_Address = w_Addr_Live ? w_Src_Live : r_Src_Hold;
        io_Mem.o_Dst_Address = w_Addr_Live ? w_Dst_Live : r_Dst_Hold;
    end

endmodule
